// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with exact occupancy count, registered
// threshold flags and sticky overflow/underflow flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
// leave it undefined for registered-output reads with one cycle of latency.
module sync_fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic                  i_clr_err,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [PTR_WIDTH:0]    o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  count_next;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  wr_accept;
  logic                  rd_accept;

  // Accept decisions use the flags registered this cycle
  assign wr_accept = i_wr_en && !full_q;
  assign rd_accept = i_rd_en && !empty_q;

  // Occupancy after this edge; flags are derived from it so they stay registered
  always_comb begin
    count_next = count_q;
    if (wr_accept && !rd_accept) begin
      count_next = count_q + CNT_WIDTH'(1);
    end else if (!wr_accept && rd_accept) begin
      count_next = count_q - CNT_WIDTH'(1);
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, count and threshold flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      count_q <= count_next;
      full_q  <= (count_next == CNT_WIDTH'(FIFO_DEPTH));
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= CNT_WIDTH'(AF_LEVEL));
      ae_q    <= (count_next <= CNT_WIDTH'(AE_LEVEL));
    end
  end

  // Sticky error flags; a new error in the same cycle beats the clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (i_wr_en && full_q) begin
        ovf_q <= 1'b1;
      end else if (i_clr_err) begin
        ovf_q <= 1'b0;
      end
      if (i_rd_en && empty_q) begin
        unf_q <= 1'b1;
      end else if (i_clr_err) begin
        unf_q <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented whenever data is held; zero while empty
  assign o_rd_data = empty_q ? '0 : mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Registered read: load the head word on the edge that accepts the pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else if (rd_accept) begin
      rd_data_q <= mem[rd_ptr];
    end
  end

  assign o_rd_data = rd_data_q;
`endif

  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
  assign o_count        = count_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO with occupancy count, threshold flags and sticky error flags. It is the same-clock companion to the dual-clock `async_fifo` and buffers streams between blocks in one clock domain. It needs no pointer synchronisers, which lets it report exact occupancy every cycle and provide flags the dual-clock FIFO lacks. Read mode is either registered-output or first-word-fall-through (FWFT), selected at compile time.

## Interface
- `DATA_WIDTH`, 8, word width in bits.
- `FIFO_DEPTH`, 16, number of entries; power of two, at least 2.
- `AF_LEVEL`, `FIFO_DEPTH-2`, `o_almost_full` threshold; must satisfy 1 ≤ `AF_LEVEL` ≤ `FIFO_DEPTH`.
- `AE_LEVEL`, 2, `o_almost_empty` threshold; must satisfy 0 ≤ `AE_LEVEL` < `FIFO_DEPTH`.
- `PTR_WIDTH` is derived as `$clog2(FIFO_DEPTH)`.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` input 1: sole clock; all state changes on its rising edge.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_wr_en` input 1: write request.
- `i_wr_data` input `DATA_WIDTH`: write word.
- `i_rd_en` input 1: read request (pop).
- `i_clr_err` input 1: clears the sticky error flags.
- `o_rd_data` output `DATA_WIDTH`: read word.
- `o_full` output 1: count == `FIFO_DEPTH`.
- `o_empty` output 1: count == 0.
- `o_almost_full` output 1: count ≥ `AF_LEVEL`.
- `o_almost_empty` output 1: count ≤ `AE_LEVEL`.
- `o_count` output `PTR_WIDTH+1`: current occupancy, 0 to `FIFO_DEPTH`.
- `o_overflow` output 1: sticky; set by a write attempted while full.
- `o_underflow` output 1: sticky; set by a read attempted while empty.

## Operation
- Accept rules:
  - A write is accepted when `i_wr_en && !o_full`.
  - A read is accepted when `i_rd_en && !o_empty`.
  - Both use the registered flag values from the current cycle.
- Pointers:
  - Write and read pointers are `PTR_WIDTH` bits and wrap naturally from `FIFO_DEPTH-1` to 0.
  - The write pointer advances only on an accepted write; the read pointer only on an accepted read.
- Memory: storage is `FIFO_DEPTH` × `DATA_WIDTH`, written on an accepted write, and not reset.
- Count:
  - Accepted write only: count +1.
  - Accepted read only: count −1.
  - Both accepted: count unchanged.
  - Neither: count unchanged.
- Status flags: all flags are registered and computed from the next count, so they are never combinational from the inputs.
- Boundary cases:
  - Full, with read and write requested together: the write is rejected and `o_overflow` is set; the read is accepted and count becomes `FIFO_DEPTH-1`.
  - Empty, with read and write requested together: the read is rejected and `o_underflow` is set; the write is accepted and count becomes 1.
- Sticky errors:
  - `o_overflow` is set when `i_wr_en && o_full`; `o_underflow` is set when `i_rd_en && o_empty`.
  - Both clear when `i_clr_err` is high.
  - If a set and a clear occur in the same cycle, the set wins.
- Reset (asynchronous assertion):
  - Pointers are zeroed, count is 0 and `o_rd_data` is 0.
  - `o_empty` = 1, `o_almost_empty` = 1, `o_full` = 0, `o_almost_full` = 0.
  - `o_overflow` = 0, `o_underflow` = 0.
  - Reset asserted mid-operation discards all contents. The first accepted write after release goes to address 0.

## Timing
- Write to `o_empty` deasserted: 1 cycle. The flag falls on the edge that stores the word.
- Accepted read to `o_full` deasserted: 1 cycle.
- Registered mode (macro undefined):
  - `o_rd_data` loads `mem[rdptr]` on the edge that accepts a read, so data is valid in the cycle after the read request.
  - `o_rd_data` holds its value otherwise.
- FWFT mode:
  - `o_rd_data` presents the head word combinationally whenever `o_empty` is 0. A word therefore becomes visible 1 cycle after it is written into an empty FIFO.
  - `i_rd_en` acknowledges and pops the presented word.
  - While `o_empty` is 1, `o_rd_data` is don't-care.
- Throughput: one write and one read per cycle are sustained when the FIFO is neither full nor empty.

## Configuration
- `SYNC_FIFO_FWFT_EN`:
  - Defined: FWFT read behaviour as described under Timing.
  - Undefined: registered-output read with 1-cycle read latency.
- Flags, count and error behaviour are identical in both builds.

## Test plan
- Reset, then write 0x01–0x10 with `DATA_WIDTH`=8, `FIFO_DEPTH`=16:
  - `o_almost_full` rises when count reaches 14.
  - `o_full` rises after the 16th write.
  - A 17th write sets `o_overflow`; count stays 16.
- Read all 16 words:
  - Data comes out as 0x01–0x10 in order (next cycle in registered mode; on the bus before each pop in FWFT).
  - `o_almost_empty` rises at count 2; `o_empty` rises after the last read.
  - An extra read sets `o_underflow`.
- Continuous simultaneous read and write at count 8 for 40 cycles:
  - Count stays 8 and the flags never toggle.
  - Data order is preserved across pointer wrap-around.
- Full, with `i_wr_en` and `i_rd_en` together: count goes to 15 and `o_overflow` is set. Empty, with both together: count goes to 1 and `o_underflow` is set.
- Assert `i_clr_err` alone: both sticky flags clear. Assert it in the same cycle as an overflowing write: `o_overflow` remains 1.
- Assert `i_rst_n` low asynchronously at count 9:
  - Outputs immediately take their reset values.
  - After release, writing 0xAA then reading returns 0xAA.
